gray_counter_enc: RTL
=====================

GRAY_COUNTER_ENC -- requirements
Module: gray_counter_enc

Interface
REQ-001: Parameter WIDTH, default 4, SHALL set the counter and code width in bits (legal range 2..16).
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004: en  input  1  SHALL enable a count step in the current cycle.
REQ-005: up  input  1  SHALL set direction: 1 = increment, 0 = decrement; sampled only when en=1.
REQ-006: load  input  1  SHALL request a synchronous load of load_bin.
REQ-007: load_bin  input  WIDTH  SHALL be the binary value to load.
REQ-008: bin  output  WIDTH  SHALL be the registered binary count.
REQ-009: gray  output  WIDTH  SHALL be the registered Gray encoding of bin.
REQ-010: tc  output  1  SHALL be combinational terminal-count: en=1 and load=0 and ((up=1 and bin=all-ones) or (up=0 and bin=0)).
REQ-011: wrap  output  1  SHALL be a registered one-cycle pulse marking that the count wrapped on the previous edge.

Function
REQ-012: Encoding SHALL be gray[WIDTH-1]=bin[WIDTH-1], gray[i]=bin[i+1] XOR bin[i] for i<WIDTH-1.
REQ-013: gray SHALL be held in its own register, updated on the same edge as bin from the next-state binary value, so gray always equals encode(bin) with zero cycles of skew.
REQ-014: Priority per edge: load > en > hold.
REQ-015: load=1: bin <= load_bin, gray <= encode(load_bin), wrap <= 0, regardless of en/up.
REQ-016: load=0, en=1, up=1: bin <= bin+1 modulo 2^WIDTH.
REQ-017: load=0, en=1, up=0: bin <= bin-1 modulo 2^WIDTH.
REQ-018: load=0, en=0: bin, gray hold; wrap <= 0.
REQ-019: wrap SHALL be set to 1 on an edge where tc=1 (all-ones -> 0 going up, 0 -> all-ones going down), else 0.
REQ-020: Any count step (REQ-016/017) SHALL change exactly one bit of gray, including across wrap.
REQ-021: Direction changes SHALL take effect the same edge up changes; no dead cycle.
REQ-022: Arithmetic SHALL be WIDTH bits unsigned; no carry/borrow output other than tc/wrap.

Reset
REQ-023: rst_n=0 SHALL immediately, without clk, force bin=0, gray=0, wrap=0.
REQ-024: While rst_n=0, load and en SHALL be ignored; tc SHALL still follow REQ-010 with bin=0.
REQ-025: First edge after rst_n deasserts SHALL be a normal functional edge; reset mid-count SHALL discard the count with no residual wrap pulse.

Verification (WIDTH=4)
REQ-026: Reset, then en=1, up=1 for 17 edges -> gray sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000; tc=1 only while bin=1111; wrap=1 exactly one cycle after bin returns to 0000.
REQ-027: From bin=0000, en=1, up=0, one edge -> bin=1111, gray=1000, wrap=1 next cycle; tc was 1 before that edge.
REQ-028: load=1, load_bin=1010, en=1, up=1 on the same edge -> bin=1010, gray=1111, wrap=0 (load wins).
REQ-029: Count up to bin=0101 (gray 0111), drop rst_n between clock edges -> bin=0000, gray=0000, wrap=0 before the next edge; resume after release from 0000.
REQ-030: Random en/up/load over 1000 cycles -> scoreboard checks gray==encode(bin) every cycle, and Hamming distance of gray across every non-load step is exactly 1 (0 on hold).

Source files
------------

// File: rtl/gray_counter_enc.sv
`default_nettype none
// ============================================================================
// Module      : gray_counter_enc
// Description : Up/down binary counter with synchronous load, a registered
//               Gray-code output and terminal-count / wrap indications.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_counter_enc #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_zero     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_wrap;

    logic [WIDTH-1:0] w_bin_nxt;
    logic             w_at_max;
    logic             w_at_min;
    logic             w_tc;

    function automatic logic [WIDTH-1:0] f_bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign w_at_max = (r_bin == c_all_ones);
    assign w_at_min = (r_bin == c_zero);

    // Load masks the terminal count, so a loaded edge never produces a wrap.
    assign w_tc = en & ~load & ((up & w_at_max) | (~up & w_at_min));

    always_comb begin
        w_bin_nxt = r_bin;
        if (load) begin
            w_bin_nxt = load_bin;
        end else if (en) begin
            if (up) begin
                w_bin_nxt = r_bin + c_one;
            end else begin
                w_bin_nxt = r_bin - c_one;
            end
        end
    end

    // Gray is encoded from the next binary value so both registers move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= c_zero;
            r_gray <= c_zero;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= f_bin2gray(w_bin_nxt);
            r_wrap <= w_tc;
        end
    end

    assign bin  = r_bin;
    assign gray = r_gray;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule
`default_nettype wire
